// File: rtl/csr_counter_unit_pkg.sv
// Shared CSR addresses, funct3 encodings and mcountinhibit bit positions
// for the EX-stage CSR/counter unit.
package csr_counter_unit_pkg;

    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
    localparam logic [11:0] CSR_CYCLE         = 12'hC00;
    localparam logic [11:0] CSR_INSTRET       = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER3   = 12'hC03;

    // addr[11:8] of the machine-writable and user read-only counter windows
    localparam logic [3:0] CNT_M_BASE = 4'hB;
    localparam logic [3:0] CNT_U_BASE = 4'hC;

    localparam int INH_CY   = 0;
    localparam int INH_IR   = 2;
    localparam int INH_HPM0 = 3;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

endpackage

// File: rtl/csr_counter_unit_if.sv
// EX-stage CSR request/response bundle: instruction fields, retire/event
// inputs and the read-data / illegal response.
interface csr_counter_unit_if #(
    parameter int XLEN    = 32,
    parameter int NUM_HPM = 4,
    parameter int RET_W   = 2
);
    logic               csr_valid;
    logic               stall;
    logic               flush;
    logic [2:0]         function_3;
    logic [11:0]        csr_addr;
    logic [4:0]         rs1_idx;
    logic [XLEN-1:0]    rs1_data;
    logic [RET_W-1:0]   retire_cnt;
    logic [NUM_HPM-1:0] hpm_event;
    logic [XLEN-1:0]    csr_rd_data;
    logic               csr_illegal;

    modport master (
        output csr_valid, stall, flush, function_3, csr_addr, rs1_idx, rs1_data,
               retire_cnt, hpm_event,
        input  csr_rd_data, csr_illegal
    );

    modport slave (
        input  csr_valid, stall, flush, function_3, csr_addr, rs1_idx, rs1_data,
               retire_cnt, hpm_event,
        output csr_rd_data, csr_illegal
    );
endinterface

// File: rtl/csr_counter_unit_counter.sv
// One CNT_W-bit event counter with inhibit and independent lo/hi XLEN-window writes.
module csr_counter #(
    parameter int CNT_W = 64,
    parameter int INC_W = 1,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INC_W-1:0] inc,
    input  logic             inhibit,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [XLEN-1:0]  wdata,
    output logic [CNT_W-1:0] value
);
    localparam int HI_W = CNT_W - XLEN;

    logic [CNT_W-1:0] bumped, nxt;

    // A lo write drops the increment entirely; a hi write keeps the
    // incremented lo half but discards its carry.
    always_comb begin
        bumped = inhibit ? value : value + CNT_W'(inc);
        nxt    = bumped;
        if (wr_lo)
            nxt = {value[CNT_W-1:XLEN], wdata};
        else if (wr_hi)
            nxt = {wdata[HI_W-1:0], bumped[XLEN-1:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) value <= '0;
        else      value <= nxt;
    end
endmodule

// File: rtl/csr_counter_unit.sv
// EX-stage CSR unit: CSRRW/S/C(I) on mscratch, mcountinhibit and the
// cycle/instret/hpm counters, with read-only shadow and illegal detection.
module csr_counter_unit
    import csr_counter_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CNT_W   = 64,
    parameter int NUM_HPM = 4,
    parameter int RET_W   = 2
) (
    input logic               clk,
    input logic               rst,
    csr_counter_unit_if.slave bus
);
    localparam int NCNT = NUM_HPM + 2;
    localparam logic [XLEN-1:0] INH_MASK =
        XLEN'(((64'd1 << NUM_HPM) - 64'd1) << INH_HPM0) |
        XLEN'(64'd1 << INH_CY) | XLEN'(64'd1 << INH_IR);

    logic [XLEN-1:0]             mscratch, mcountinhibit;
    logic [NCNT-1:0][CNT_W-1:0]  cnt;
    logic [NCNT-1:0]             inh, wr_lo, wr_hi;

    csr_op_e         op;
    logic [4:0]      ofs, cidx;
    logic            is_cnt, mapped, wr_en, commit, m_cnt_wr;
    logic [XLEN-1:0] old, src, wdata;

    always_comb begin
        op     = csr_op_e'(bus.function_3);
        ofs    = bus.csr_addr[4:0];
        // counter index: 0 cycle, 1 instret, 2+i hpm i; offset 1 (time) is absent
        cidx   = (ofs == 5'd0) ? 5'd0 : ofs - 5'd1;
        is_cnt = (bus.csr_addr[11:8] == CNT_M_BASE || bus.csr_addr[11:8] == CNT_U_BASE) &&
                 (bus.csr_addr[6:5] == 2'b00) &&
                 (ofs == 5'd0 || (ofs >= 5'd2 && {1'b0, ofs} < 6'(3 + NUM_HPM)));

        old    = '0;
        mapped = 1'b1;
        if (bus.csr_addr == CSR_MSCRATCH)
            old = mscratch;
        else if (bus.csr_addr == CSR_MCOUNTINHIBIT)
            old = mcountinhibit;
        else if (is_cnt) begin
            for (int k = 0; k < NCNT; k++)
                if (cidx == 5'(k))
                    old = bus.csr_addr[7] ? XLEN'(cnt[k][CNT_W-1:XLEN]) : cnt[k][XLEN-1:0];
        end else
            mapped = 1'b0;

        case (op)
            OP_RW, OP_RWI:                 wr_en = 1'b1;
            OP_RS, OP_RC, OP_RSI, OP_RCI:  wr_en = (bus.rs1_idx != 5'd0);
            default:                       wr_en = 1'b0;
        endcase

        src = bus.function_3[2] ? XLEN'(bus.rs1_idx) : bus.rs1_data;
        case (bus.function_3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = old | src;
            2'b11:   wdata = old & ~src;
            default: wdata = old;
        endcase

        bus.csr_illegal = bus.csr_valid &
                          (~mapped | ((bus.csr_addr[11:10] == 2'b11) & wr_en));
        bus.csr_rd_data = bus.csr_illegal ? '0 : old;
        commit   = bus.csr_valid & ~bus.stall & ~bus.flush & wr_en & ~bus.csr_illegal;
        m_cnt_wr = commit & is_cnt & (bus.csr_addr[11:8] == CNT_M_BASE);

        for (int k = 0; k < NCNT; k++) begin
            wr_lo[k] = m_cnt_wr & ~bus.csr_addr[7] & (cidx == 5'(k));
            wr_hi[k] = m_cnt_wr &  bus.csr_addr[7] & (cidx == 5'(k));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mscratch      <= '0;
            mcountinhibit <= '0;
        end else if (commit) begin
            if (bus.csr_addr == CSR_MSCRATCH)      mscratch      <= wdata;
            if (bus.csr_addr == CSR_MCOUNTINHIBIT) mcountinhibit <= wdata & INH_MASK;
        end
    end

    // Registered inhibit, so a write to mcountinhibit gates counting from the next cycle
    always_comb begin
        inh[0] = mcountinhibit[INH_CY];
        inh[1] = mcountinhibit[INH_IR];
        for (int i = 0; i < NUM_HPM; i++)
            inh[2+i] = mcountinhibit[INH_HPM0+i];
    end

    csr_counter #(.CNT_W(CNT_W), .INC_W(1), .XLEN(XLEN)) u_cycle (
        .clk(clk), .rst(rst), .inc(1'b1), .inhibit(inh[0]),
        .wr_lo(wr_lo[0]), .wr_hi(wr_hi[0]), .wdata(wdata), .value(cnt[0])
    );

    csr_counter #(.CNT_W(CNT_W), .INC_W(RET_W), .XLEN(XLEN)) u_instret (
        .clk(clk), .rst(rst), .inc(bus.retire_cnt), .inhibit(inh[1]),
        .wr_lo(wr_lo[1]), .wr_hi(wr_hi[1]), .wdata(wdata), .value(cnt[1])
    );

    for (genvar i = 0; i < NUM_HPM; i++) begin : g_hpm
        csr_counter #(.CNT_W(CNT_W), .INC_W(1), .XLEN(XLEN)) u_hpm (
            .clk(clk), .rst(rst), .inc(bus.hpm_event[i]), .inhibit(inh[2+i]),
            .wr_lo(wr_lo[2+i]), .wr_hi(wr_hi[2+i]), .wdata(wdata), .value(cnt[2+i])
        );
    end
endmodule

// File: tb/tb_csr_counter_unit.sv
// Directed CSR/counter sequence; expected responses are queued at issue and
// checked by an independent monitor whenever a CSR op is presented.
module tb_csr_counter_unit;
    localparam int XLEN = 32, CNT_W = 64, NUM_HPM = 4, RET_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    csr_counter_unit_if #(.XLEN(XLEN), .NUM_HPM(NUM_HPM), .RET_W(RET_W)) bus ();

    csr_counter_unit #(.XLEN(XLEN), .CNT_W(CNT_W), .NUM_HPM(NUM_HPM), .RET_W(RET_W)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [XLEN-1:0] rd;
        logic            ill;
        int              id;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step   = 0;

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011;
    localparam logic [2:0] RWI = 3'b101, RSI = 3'b110, RCI = 3'b111;

    // Drive one CSR op for exactly one cycle; caller is at posedge+1.
    task automatic csr_op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] idx,
                          input logic [XLEN-1:0] d, input logic [XLEN-1:0] erd,
                          input logic eill, input logic st = 1'b0, input logic fl = 1'b0);
        exp_t e;
        step++;
        e.rd = erd; e.ill = eill; e.id = step;
        q.push_back(e);
        bus.csr_valid  = 1'b1;
        bus.function_3 = f3;
        bus.csr_addr   = a;
        bus.rs1_idx    = idx;
        bus.rs1_data   = d;
        bus.stall      = st;
        bus.flush      = fl;
        @(posedge clk); #1;
        bus.csr_valid  = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic rd_csr(input logic [11:0] a, input logic [XLEN-1:0] erd);
        csr_op(RS, a, 5'd0, 32'h0, erd, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.csr_valid) begin
            if (q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_op: response with empty scoreboard");
            end else begin
                exp_t e;
                e = q.pop_front();
                n_chk++;
                if (bus.csr_rd_data !== e.rd) begin
                    n_fail++;
                    $display("FAIL op%0d_rd: got %h expected %h", e.id, bus.csr_rd_data, e.rd);
                end
                n_chk++;
                if (bus.csr_illegal !== e.ill) begin
                    n_fail++;
                    $display("FAIL op%0d_illegal: got %b expected %b", e.id, bus.csr_illegal, e.ill);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.csr_valid = 0; bus.stall = 0; bus.flush = 0; bus.function_3 = 0;
        bus.csr_addr = 0; bus.rs1_idx = 0; bus.rs1_data = 0;
        bus.retire_cnt = 0; bus.hpm_event = 0;
        idle(3);
        // reset state
        rd_csr(12'hC00, 32'h0);
        rd_csr(12'h340, 32'h0);
        rst = 1'b1;
        idle(10);
        rd_csr(12'hC00, 32'd10);
        rd_csr(12'hC80, 32'd0);
        // mscratch RW / RS-no-write / RC / RSI / RCI
        csr_op(RW,  12'h340, 5'd1, 32'hDEADBEEF, 32'h0, 1'b0);
        csr_op(RS,  12'h340, 5'd0, 32'h12345678, 32'hDEADBEEF, 1'b0);
        rd_csr(12'h340, 32'hDEADBEEF);
        csr_op(RC,  12'h340, 5'd5, 32'h0000FFFF, 32'hDEADBEEF, 1'b0);
        csr_op(RSI, 12'h340, 5'd3, 32'h0, 32'hDEAD0000, 1'b0);
        csr_op(RCI, 12'h340, 5'd1, 32'h0, 32'hDEAD0003, 1'b0);
        rd_csr(12'h340, 32'hDEAD0002);
        // mcycle hi/lo split writes and carry (lo=19 at this point)
        csr_op(RW,  12'hB80, 5'd1, 32'd5, 32'd0, 1'b0);
        csr_op(RW,  12'hB00, 5'd1, 32'hFFFF_FFF0, 32'd20, 1'b0);
        csr_op(RWI, 12'hB00, 5'd0, 32'h0, 32'hFFFF_FFF0, 1'b0);
        rd_csr(12'hC80, 32'd5);
        rd_csr(12'hC00, 32'd1);
        csr_op(RW,  12'hB00, 5'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        rd_csr(12'hC80, 32'd5);
        rd_csr(12'hC80, 32'd6);
        rd_csr(12'hC00, 32'd1);
        // read-only shadow and unmapped addresses
        csr_op(RW,  12'hB02, 5'd1, 32'h100, 32'h0, 1'b0);
        csr_op(RW,  12'hC02, 5'd1, 32'h55, 32'h0, 1'b1);
        rd_csr(12'hC02, 32'h100);
        csr_op(RS,  12'hB01, 5'd0, 32'h0, 32'h0, 1'b1);
        csr_op(RS,  12'hB07, 5'd0, 32'h0, 32'h0, 1'b1);
        csr_op(RSI, 12'hC03, 5'd0, 32'h0, 32'h0, 1'b0);
        // mcountinhibit mask and per-counter inhibit
        csr_op(RW,  12'hB00, 5'd1, 32'h1000, 32'd8, 1'b0);
        csr_op(RW,  12'h320, 5'd1, 32'hFFFF_FFFF, 32'h0, 1'b0);
        rd_csr(12'h320, 32'h7D);
        csr_op(RW,  12'h320, 5'd1, 32'h5, 32'h7D, 1'b0);
        bus.retire_cnt = 2'd2; bus.hpm_event = 4'b0001;
        idle(5);
        rd_csr(12'hC00, 32'h1001);
        rd_csr(12'hC02, 32'h100);
        rd_csr(12'hC03, 32'd7);
        csr_op(RCI, 12'h320, 5'd5, 32'h0, 32'h5, 1'b0);
        idle(5);
        rd_csr(12'hC02, 32'h10A);
        rd_csr(12'hC00, 32'h1007);
        bus.retire_cnt = 2'd0; bus.hpm_event = 4'b0000;
        // stall / flush suppress commit
        csr_op(RW,  12'h340, 5'd1, 32'h11111111, 32'hDEAD0002, 1'b0, 1'b1, 1'b0);
        csr_op(RW,  12'h340, 5'd1, 32'h22222222, 32'hDEAD0002, 1'b0, 1'b0, 1'b1);
        rd_csr(12'h340, 32'hDEAD0002);
        // reset mid-count
        bus.retire_cnt = 2'd3; bus.hpm_event = 4'b1111;
        idle(3);
        rst = 1'b0;
        rd_csr(12'hC00, 32'h0);
        rd_csr(12'hC02, 32'h0);
        rd_csr(12'hC03, 32'h0);
        rd_csr(12'h340, 32'h0);
        rd_csr(12'h320, 32'h0);
        rst = 1'b1;
        rd_csr(12'hC00, 32'd0);
        rd_csr(12'hC00, 32'd1);
        rd_csr(12'hC02, 32'd6);
        rd_csr(12'hC06, 32'd3);
        @(negedge clk);
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
